// File: rtl/axi_slice_pkg.sv
// Shared AXI definitions for this slice: response codes and the write-response selector.
package axi_slice_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] resp_sel(input logic err, input logic [1:0] err_resp);
    if (err) begin
      return err_resp;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_wr_id_fifo.sv
// Synchronous FIFO holding accepted AW {id, user, err} entries in arrival order.
// Full/empty derive from a registered occupancy counter only, so a same-cycle pop never frees a slot early.
module axi_wr_id_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   occ_r;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (occ_r == OCC_FULL);
  assign empty_o = (occ_r == '0);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign data_o  = mem_r[rd_ptr_r];

  // Storage array and write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
      wr_ptr_r        <= wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_b_resp_gen.sv
// AXI slave write-response generator: pairs each AW (in order) with a W-last token
// and presents one B response per pair from a single output register.
module axi_b_resp_gen
  import axi_slice_pkg::*;
#(
  parameter int         ID_WIDTH   = 4,
  parameter int         USER_WIDTH = 1,
  parameter int         AW_DEPTH   = 4,
  parameter int         MAX_PEND_W = 4,
  parameter logic [1:0] ERR_RESP   = RESP_DECERR
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  aw_valid_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [USER_WIDTH-1:0] aw_user_i,
  input  logic                  aw_err_i,
  output logic                  aw_ready_o,
  input  logic                  wlast_valid_i,
  output logic                  wlast_ready_o,
  output logic                  b_valid_o,
  output logic [1:0]            b_resp_o,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [USER_WIDTH-1:0] b_user_o,
  input  logic                  b_ready_i
);

  localparam int ENTRY_W = ID_WIDTH + USER_WIDTH + 1;
  localparam int CNT_W   = $clog2(MAX_PEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [ENTRY_W-1:0]    head_s;
  logic [ID_WIDTH-1:0]   head_id_s;
  logic [USER_WIDTH-1:0] head_user_s;
  logic                  head_err_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  aw_push_s;
  logic                  tok_inc_s;
  logic                  pair_avail_s;
  logic                  b_load_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  b_valid_r;
  logic [1:0]            b_resp_r;
  logic [ID_WIDTH-1:0]   b_id_r;
  logic [USER_WIDTH-1:0] b_user_r;

  assign aw_ready_o    = !fifo_full_s;
  assign wlast_ready_o = (cnt_r < CNT_MAX);
  assign aw_push_s     = aw_valid_i && aw_ready_o;
  assign tok_inc_s     = wlast_valid_i && wlast_ready_o;
  assign pair_avail_s  = !fifo_empty_s && (cnt_r != '0);
  // Reload is allowed while the current response is being accepted, giving one B per cycle.
  assign b_load_s      = pair_avail_s && (!b_valid_r || b_ready_i);

  assign {head_id_s, head_user_s, head_err_s} = head_s;

  axi_wr_id_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_push_s),
    .data_i  ({aw_id_i, aw_user_i, aw_err_i}),
    .pop_i   (b_load_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // W-last token counter; tokens may run ahead of their AW.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else begin
      case ({tok_inc_s, b_load_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // B output register; payload only changes on a load, so it holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_r <= 1'b0;
      b_resp_r  <= RESP_OKAY;
      b_id_r    <= '0;
      b_user_r  <= '0;
    end else if (b_load_s) begin
      b_valid_r <= 1'b1;
      b_resp_r  <= resp_sel(head_err_s, ERR_RESP);
      b_id_r    <= head_id_s;
      b_user_r  <= head_user_s;
    end else if (b_ready_i) begin
      b_valid_r <= 1'b0;
    end else begin
      b_valid_r <= b_valid_r;
    end
  end

  assign b_valid_o = b_valid_r;
  assign b_resp_o  = b_resp_r;
  assign b_id_o    = b_id_r;
  assign b_user_o  = b_user_r;

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed self-checking bench for axi_b_resp_gen; a second instance uses ERR_RESP=SLVERR.
module tb_axi_b_resp_gen;
  import axi_slice_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       aw_valid;
  logic [3:0] aw_id;
  logic [0:0] aw_user;
  logic       aw_err;
  logic       aw_ready, aw_ready2;
  logic       wlast_valid;
  logic       wlast_ready, wlast_ready2;
  logic       b_valid, b_valid2;
  logic [1:0] b_resp, b_resp2;
  logic [3:0] b_id, b_id2;
  logic [0:0] b_user, b_user2;
  logic       b_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] got_id[$];
  logic [1:0] got_resp[$];

  always #5 clk = ~clk;

  axi_b_resp_gen dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_err_i(aw_err),
    .aw_ready_o(aw_ready), .wlast_valid_i(wlast_valid), .wlast_ready_o(wlast_ready),
    .b_valid_o(b_valid), .b_resp_o(b_resp), .b_id_o(b_id), .b_user_o(b_user),
    .b_ready_i(b_ready)
  );

  axi_b_resp_gen #(.ERR_RESP(RESP_SLVERR)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_err_i(aw_err),
    .aw_ready_o(aw_ready2), .wlast_valid_i(wlast_valid), .wlast_ready_o(wlast_ready2),
    .b_valid_o(b_valid2), .b_resp_o(b_resp2), .b_id_o(b_id2), .b_user_o(b_user2),
    .b_ready_i(b_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of AW and/or W-last stimulus, then idle inputs.
  task automatic send(input logic aw, input logic [3:0] id, input logic usr,
                      input logic err, input logic wl);
    aw_valid    = aw;
    aw_id       = id;
    aw_user     = usr;
    aw_err      = err;
    wlast_valid = wl;
    tick();
    aw_valid    = 1'b0;
    aw_id       = 4'h0;
    aw_user     = 1'b0;
    aw_err      = 1'b0;
    wlast_valid = 1'b0;
  endtask

  // Accept B responses with b_ready high until n are seen or the cycle budget runs out.
  task automatic drain(input int n);
    int cyc = 0;
    got_id.delete();
    got_resp.delete();
    b_ready = 1'b1;
    while (got_id.size() < n && cyc < 40) begin
      if (b_valid) begin
        got_id.push_back(b_id);
        got_resp.push_back(b_resp);
      end
      tick();
      cyc++;
    end
    b_ready = 1'b0;
    check_eq("drain_count", got_id.size(), n);
  endtask

  initial begin
    rst_n = 1'b0; aw_valid = 1'b0; aw_id = 4'h0; aw_user = 1'b0; aw_err = 1'b0;
    wlast_valid = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_aw_ready", aw_ready, 1);
    check_eq("rst_wlast_ready", wlast_ready, 1);
    check_eq("rst_b_valid", b_valid, 0);
    check_eq("rst_b_resp", b_resp, 0);
    check_eq("rst_b_id", b_id, 0);
    check_eq("rst_b_user", b_user, 0);
    rst_n = 1'b1;
    tick();

    // Single write
    send(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("single_valid", b_valid, 1);
    check_eq("single_resp", b_resp, 2'b00);
    check_eq("single_id", b_id, 4'd3);
    check_eq("single_user", b_user, 1);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check_eq("single_deassert", b_valid, 0);

    // W-last tokens ahead of their AWs
    for (int i = 0; i < 4; i++) send(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("wfirst_wlast_ready_lo", wlast_ready, 0);
    check_eq("wfirst_no_b", b_valid, 0);
    for (int i = 1; i <= 4; i++) send(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_id.size()) check_eq("wfirst_order", got_id[i], i + 1);
    end
    check_eq("wfirst_wlast_ready_hi", wlast_ready, 1);

    // AW backpressure
    for (int i = 6; i <= 9; i++) send(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    aw_valid = 1'b1;
    aw_id    = 4'd10;
    check_eq("bp_aw_ready_lo", aw_ready, 0);
    tick();
    aw_valid = 1'b0;
    aw_id    = 4'd0;
    send(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("bp_b_valid", b_valid, 1);
    check_eq("bp_b_id", b_id, 4'd6);
    check_eq("bp_aw_ready_hi", aw_ready, 1);
    for (int i = 0; i < 3; i++) send(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_id.size()) check_eq("bp_order", got_id[i], i + 6);
    end

    // Error response code in both instances
    send(1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("err_valid", b_valid, 1);
    check_eq("err_resp_decerr", b_resp, 2'b11);
    check_eq("err_id", b_id, 4'd5);
    check_eq("err_resp_slverr", b_resp2, 2'b10);
    check_eq("err_id2", b_id2, 4'd5);
    drain(1);
    if (got_resp.size() > 0) check_eq("err_drained_resp", got_resp[0], 2'b11);

    // Downstream stall with 3 pairs pending
    send(1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
    send(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    send(1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", b_valid, 1);
      check_eq("stall_id", b_id, 4'hA);
      check_eq("stall_user", b_user, 1);
      check_eq("stall_resp", b_resp, 2'b00);
      tick();
    end
    b_ready = 1'b1;
    check_eq("b2b_0_valid", b_valid, 1);
    check_eq("b2b_0_id", b_id, 4'hA);
    tick();
    check_eq("b2b_1_valid", b_valid, 1);
    check_eq("b2b_1_id", b_id, 4'hB);
    check_eq("b2b_1_user", b_user, 0);
    tick();
    check_eq("b2b_2_valid", b_valid, 1);
    check_eq("b2b_2_id", b_id, 4'hC);
    tick();
    check_eq("b2b_empty", b_valid, 0);
    b_ready = 1'b0;

    // Reset in the middle of pending traffic
    send(1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
    send(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    check_eq("mid_valid", b_valid, 1);
    check_eq("mid_id", b_id, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_b_valid", b_valid, 0);
    check_eq("arst_b_resp", b_resp, 0);
    check_eq("arst_b_id", b_id, 0);
    check_eq("arst_b_user", b_user, 0);
    check_eq("arst_aw_ready", aw_ready, 1);
    check_eq("arst_wlast_ready", wlast_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("post_rst_no_b", b_valid, 0);
    end
    b_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
